// File: rtl/axi_llc_evict_seq_pkg.sv
// Shared types for the LLC evict sequencer: the LLC configuration it is sized from
// and its FSM state encoding.
package axi_llc_evict_seq_pkg;

    typedef struct packed {
        int unsigned SetAssociativity;
        int unsigned IndexLength;
    } llc_cfg_t;

    localparam llc_cfg_t DefaultLlcCfg = '{SetAssociativity: 32'd8, IndexLength: 32'd4};

    typedef enum logic {
        IDLE,
        ISSUE
    } evict_seq_state_e;

endpackage

// File: rtl/axi_llc_evict_seq_fifo.sv
// Registered-output (non fall-through) descriptor FIFO with occupancy count,
// so the sequencer can reserve a slot before accepting a lookup.
module axi_llc_evict_seq_fifo #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 2,
    localparam int unsigned AddrW    = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned UsageW   = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 empty_o,
    output logic [UsageW-1:0]    usage_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [UsageW-1:0]    usage_q;
    logic                 pop;

    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign pop     = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_i && !pop) begin
                usage_q <= usage_q + 1'b1;
            end else if (!push_i && pop) begin
                usage_q <= usage_q - 1'b1;
            end
        end
    end

    // The sequencer reserves space at accept time, so a push into a full FIFO is a bug.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i |-> (usage_q != UsageW'(Depth)) || pop);

endmodule

// File: rtl/axi_llc_evict_seq.sv
// Sequencer in front of the LLC evict box: issues hit/evict requests, waits for the
// answer and queues way/index/writeback descriptors for the refill stage.
module axi_llc_evict_seq
    import axi_llc_evict_seq_pkg::*;
#(
    parameter llc_cfg_t    Cfg           = DefaultLlcCfg,
    parameter type         way_ind_t     = logic [Cfg.SetAssociativity-1:0],
    parameter int unsigned FifoDepth     = 32'd2,
    parameter int unsigned TimeoutCycles = 32'd16,
    localparam int unsigned W            = Cfg.SetAssociativity,
    localparam int unsigned IL           = Cfg.IndexLength,
    localparam int unsigned DescW        = W + IL + 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bist_i,
    input  logic             lu_valid_i,
    output logic             lu_ready_o,
    input  logic             lu_hit_i,
    input  way_ind_t         lu_hit_way_i,
    input  logic [IL-1:0]    lu_index_i,
    input  way_ind_t         lu_tag_valid_i,
    input  way_ind_t         lu_tag_dirty_i,
    input  way_ind_t         lu_spm_lock_i,
    output logic             hit_o,
    output logic             evict_o,
    output way_ind_t         res_indicator_o,
    output logic [IL-1:0]    ram_index_o,
    output way_ind_t         tag_dirty_o,
    output way_ind_t         tag_valid_o,
    output way_ind_t         spm_lock_o,
    input  way_ind_t         eb_way_ind_i,
    input  logic             eb_evict_i,
    input  logic             eb_valid_i,
    input  logic             eb_valid_plru_i,
    output logic             desc_valid_o,
    input  logic             desc_ready_i,
    output logic [DescW-1:0] desc_o,
    output logic             err_timeout_o
);

    localparam int unsigned CntW   = $clog2(TimeoutCycles + 1);
    localparam int unsigned UsageW = $clog2(FifoDepth + 1);

    typedef struct packed {
        way_ind_t      way;
        logic [IL-1:0] index;
        logic          hit;
        logic          writeback;
        logic          no_way;
    } evict_desc_t;

    typedef struct packed {
        logic          hit;
        way_ind_t      hit_way;
        logic [IL-1:0] index;
        way_ind_t      tag_valid;
        way_ind_t      tag_dirty;
        way_ind_t      spm_lock;
    } evict_req_t;

    evict_seq_state_e state_q, state_d;
    evict_req_t       req_q, req_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push;
    evict_desc_t      push_desc;
    logic             fifo_empty;
    logic [UsageW-1:0] fifo_usage;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        lu_ready_o = 1'b0;
        hit_o      = 1'b0;
        evict_o    = 1'b0;
        push       = 1'b0;
        push_desc  = '0;
        unique case (state_q)
            IDLE: begin
                // rst_ni keeps ready low while reset is held, since it is combinational.
                lu_ready_o = rst_ni && !bist_i && (fifo_usage < UsageW'(FifoDepth));
                if (lu_valid_i && lu_ready_o) begin
                    if (!lu_hit_i && (&lu_spm_lock_i)) begin
                        push             = 1'b1;
                        push_desc.index  = lu_index_i;
                        push_desc.no_way = 1'b1;
                    end else begin
                        req_d.hit       = lu_hit_i;
                        req_d.hit_way   = lu_hit_way_i;
                        req_d.index     = lu_index_i;
                        req_d.tag_valid = lu_tag_valid_i;
                        req_d.tag_dirty = lu_tag_dirty_i;
                        req_d.spm_lock  = lu_spm_lock_i;
                        cnt_d           = '0;
                        state_d         = ISSUE;
                    end
                end
            end
            ISSUE: begin
                hit_o   = req_q.hit;
                evict_o = !req_q.hit;
                if (req_q.hit && eb_valid_plru_i) begin
                    push            = 1'b1;
                    push_desc.way   = req_q.hit_way;
                    push_desc.index = req_q.index;
                    push_desc.hit   = 1'b1;
                    state_d         = IDLE;
                end else if (!req_q.hit && eb_valid_i) begin
                    push                = 1'b1;
                    push_desc.way       = eb_way_ind_i;
                    push_desc.index     = req_q.index;
                    push_desc.writeback = eb_evict_i;
                    state_d             = IDLE;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_indicator_o = (state_q == ISSUE && req_q.hit) ? req_q.hit_way : '0;
    assign ram_index_o     = req_q.index;
    assign tag_dirty_o     = req_q.tag_dirty;
    assign tag_valid_o     = req_q.tag_valid;
    assign spm_lock_o      = req_q.spm_lock;
    assign err_timeout_o   = err_q;
    assign desc_valid_o    = !fifo_empty;

    axi_llc_evict_seq_fifo #(
        .DataWidth(DescW),
        .Depth    (FifoDepth)
    ) i_desc_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .data_i (push_desc),
        .pop_i  (desc_ready_i),
        .data_o (desc_o),
        .empty_o(fifo_empty),
        .usage_o(fifo_usage)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ISSUE && !req_q.hit && eb_valid_i) |-> $onehot(eb_way_ind_i));

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(hit_o && evict_o));

endmodule

// File: tb/tb_axi_llc_evict_seq.sv
// Directed bench for the LLC evict sequencer: W=8, IL=4, FifoDepth=2, TimeoutCycles=16.
module tb_axi_llc_evict_seq;

    logic        clk_i, rst_ni, bist_i;
    logic        lu_valid_i, lu_ready_o, lu_hit_i;
    logic [7:0]  lu_hit_way_i, lu_tag_valid_i, lu_tag_dirty_i, lu_spm_lock_i;
    logic [3:0]  lu_index_i, ram_index_o;
    logic        hit_o, evict_o;
    logic [7:0]  res_indicator_o, tag_dirty_o, tag_valid_o, spm_lock_o, eb_way_ind_i;
    logic        eb_evict_i, eb_valid_i, eb_valid_plru_i;
    logic        desc_valid_o, desc_ready_i, err_timeout_o;
    logic [14:0] desc_o;

    int checks = 0;
    int errors = 0;

    axi_llc_evict_seq #(
        .FifoDepth    (2),
        .TimeoutCycles(16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bist_i         (bist_i),
        .lu_valid_i     (lu_valid_i),
        .lu_ready_o     (lu_ready_o),
        .lu_hit_i       (lu_hit_i),
        .lu_hit_way_i   (lu_hit_way_i),
        .lu_index_i     (lu_index_i),
        .lu_tag_valid_i (lu_tag_valid_i),
        .lu_tag_dirty_i (lu_tag_dirty_i),
        .lu_spm_lock_i  (lu_spm_lock_i),
        .hit_o          (hit_o),
        .evict_o        (evict_o),
        .res_indicator_o(res_indicator_o),
        .ram_index_o    (ram_index_o),
        .tag_dirty_o    (tag_dirty_o),
        .tag_valid_o    (tag_valid_o),
        .spm_lock_o     (spm_lock_o),
        .eb_way_ind_i   (eb_way_ind_i),
        .eb_evict_i     (eb_evict_i),
        .eb_valid_i     (eb_valid_i),
        .eb_valid_plru_i(eb_valid_plru_i),
        .desc_valid_o   (desc_valid_o),
        .desc_ready_i   (desc_ready_i),
        .desc_o         (desc_o),
        .err_timeout_o  (err_timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one lookup; lu_valid_i stays high until the caller drops it.
    task automatic applyStimulus(input logic hit, input logic [7:0] way, input logic [3:0] idx,
                                 input logic [7:0] valid, input logic [7:0] dirty,
                                 input logic [7:0] lock);
        lu_valid_i     = 1'b1;
        lu_hit_i       = hit;
        lu_hit_way_i   = way;
        lu_index_i     = idx;
        lu_tag_valid_i = valid;
        lu_tag_dirty_i = dirty;
        lu_spm_lock_i  = lock;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        checks++; if (lu_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", lu_ready_o); end
        checks++; if ({hit_o, evict_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_req: got %b want 00", {hit_o, evict_o}); end
        checks++; if (desc_valid_o !== 1'b0 || desc_o !== 15'h0) begin errors++; $display("[TB] FAIL reset_desc: got %b/%h want 0/0000", desc_valid_o, desc_o); end
        checks++; if (err_timeout_o !== 1'b0 || ram_index_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_misc: got %b/%h want 0/0", err_timeout_o, ram_index_o); end
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        tick();
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b want 1", lu_ready_o); end
    endtask

    task automatic test_miss();
        applyStimulus(1'b0, 8'h00, 4'h5, 8'hFF, 8'h08, 8'h00);
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL miss_ready: got %b want 1", lu_ready_o); end
        tick();
        lu_valid_i = 1'b0;
        checks++; if ({hit_o, evict_o} !== 2'b01) begin errors++; $display("[TB] FAIL miss_evict: got %b want 01", {hit_o, evict_o}); end
        checks++; if (ram_index_o !== 4'h5 || tag_dirty_o !== 8'h08) begin errors++; $display("[TB] FAIL miss_side: got %h/%h want 5/08", ram_index_o, tag_dirty_o); end
        eb_valid_i = 1'b1; eb_way_ind_i = 8'h08; eb_evict_i = 1'b1;
        tick();
        eb_valid_i = 1'b0; eb_evict_i = 1'b0;
        checks++; if (desc_valid_o !== 1'b1 || desc_o !== {8'h08, 4'h5, 3'b010}) begin errors++; $display("[TB] FAIL miss_desc: got %b/%h want 1/%h", desc_valid_o, desc_o, {8'h08, 4'h5, 3'b010}); end
        checks++; if (evict_o !== 1'b0 || lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL miss_done: got evict %b ready %b want 0 1", evict_o, lu_ready_o); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
        checks++; if (desc_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_pop: got %b want 0", desc_valid_o); end
    endtask

    task automatic test_hit();
        applyStimulus(1'b1, 8'h20, 4'hA, 8'hFF, 8'h00, 8'h00);
        tick();
        lu_valid_i = 1'b0;
        checks++; if ({hit_o, evict_o} !== 2'b10 || res_indicator_o !== 8'h20) begin errors++; $display("[TB] FAIL hit_req: got %b/%h want 10/20", {hit_o, evict_o}, res_indicator_o); end
        tick();
        checks++; if ({hit_o, evict_o} !== 2'b10 || desc_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL hit_hold: got %b/%b want 10/0", {hit_o, evict_o}, desc_valid_o); end
        eb_valid_plru_i = 1'b1;
        tick();
        eb_valid_plru_i = 1'b0;
        checks++; if (desc_valid_o !== 1'b1 || desc_o !== {8'h20, 4'hA, 3'b100}) begin errors++; $display("[TB] FAIL hit_desc: got %b/%h want 1/%h", desc_valid_o, desc_o, {8'h20, 4'hA, 3'b100}); end
        checks++; if ({hit_o, evict_o} !== 2'b00) begin errors++; $display("[TB] FAIL hit_idle: got %b want 00", {hit_o, evict_o}); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
    endtask

    task automatic test_no_way();
        applyStimulus(1'b0, 8'h00, 4'h3, 8'hFF, 8'hFF, 8'hFF);
        tick();
        lu_valid_i = 1'b0;
        checks++; if ({hit_o, evict_o} !== 2'b00) begin errors++; $display("[TB] FAIL noway_req: got %b want 00", {hit_o, evict_o}); end
        checks++; if (desc_valid_o !== 1'b1 || desc_o !== {8'h00, 4'h3, 3'b001}) begin errors++; $display("[TB] FAIL noway_desc: got %b/%h want 1/%h", desc_valid_o, desc_o, {8'h00, 4'h3, 3'b001}); end
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL noway_ready: got %b want 1", lu_ready_o); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b0, 8'h00, 4'h1, 8'hFF, 8'h00, 8'h00);
        tick();
        lu_valid_i = 1'b0;
        eb_valid_i = 1'b1; eb_way_ind_i = 8'h02; eb_evict_i = 1'b0;
        tick();
        eb_valid_i = 1'b0;
        checks++; if (desc_o !== {8'h02, 4'h1, 3'b000} || lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got %h ready %b want %h 1", desc_o, lu_ready_o, {8'h02, 4'h1, 3'b000}); end
        desc_ready_i = 1'b1;
        applyStimulus(1'b1, 8'h04, 4'h2, 8'hFF, 8'h00, 8'h00);
        tick();
        lu_valid_i = 1'b0; desc_ready_i = 1'b0;
        checks++; if (hit_o !== 1'b1 || desc_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_issue: got hit %b dv %b want 1 0", hit_o, desc_valid_o); end
        eb_valid_plru_i = 1'b1;
        tick();
        eb_valid_plru_i = 1'b0;
        checks++; if (desc_o !== {8'h04, 4'h2, 3'b100}) begin errors++; $display("[TB] FAIL b2b_second_desc: got %h want %h", desc_o, {8'h04, 4'h2, 3'b100}); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        applyStimulus(1'b0, 8'h00, 4'h1, 8'hFF, 8'h00, 8'hFF);
        tick();
        applyStimulus(1'b0, 8'h00, 4'h2, 8'hFF, 8'h00, 8'hFF);
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL full_second_ready: got %b want 1", lu_ready_o); end
        tick();
        applyStimulus(1'b0, 8'h00, 4'h3, 8'hFF, 8'h00, 8'hFF);
        checks++; if (lu_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_stall: got %b want 0", lu_ready_o); end
        tick();
        checks++; if (lu_ready_o !== 1'b0 || desc_o !== {8'h00, 4'h1, 3'b001}) begin errors++; $display("[TB] FAIL full_stall_hold: got %b/%h want 0/%h", lu_ready_o, desc_o, {8'h00, 4'h1, 3'b001}); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL full_resume: got %b want 1", lu_ready_o); end
        tick();
        lu_valid_i = 1'b0;
        checks++; if (desc_o !== {8'h00, 4'h2, 3'b001}) begin errors++; $display("[TB] FAIL full_head2: got %h want %h", desc_o, {8'h00, 4'h2, 3'b001}); end
        desc_ready_i = 1'b1;
        tick();
        checks++; if (desc_valid_o !== 1'b1 || desc_o !== {8'h00, 4'h3, 3'b001}) begin errors++; $display("[TB] FAIL full_head3: got %b/%h want 1/%h", desc_valid_o, desc_o, {8'h00, 4'h3, 3'b001}); end
        tick();
        desc_ready_i = 1'b0;
        checks++; if (desc_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got %b want 0", desc_valid_o); end
    endtask

    task automatic test_bist();
        applyStimulus(1'b1, 8'h01, 4'h9, 8'hFF, 8'h00, 8'h00);
        tick();
        lu_valid_i = 1'b0;
        bist_i = 1'b1;
        eb_valid_plru_i = 1'b1;
        #1;
        checks++; if (hit_o !== 1'b1) begin errors++; $display("[TB] FAIL bist_inflight: got %b want 1", hit_o); end
        tick();
        eb_valid_plru_i = 1'b0;
        checks++; if (desc_valid_o !== 1'b1 || desc_o !== {8'h01, 4'h9, 3'b100}) begin errors++; $display("[TB] FAIL bist_desc: got %b/%h want 1/%h", desc_valid_o, desc_o, {8'h01, 4'h9, 3'b100}); end
        applyStimulus(1'b0, 8'h00, 4'h4, 8'hFF, 8'h00, 8'h00);
        checks++; if (lu_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bist_block: got %b want 0", lu_ready_o); end
        tick();
        checks++; if (lu_ready_o !== 1'b0 || {hit_o, evict_o} !== 2'b00) begin errors++; $display("[TB] FAIL bist_hold: got %b/%b want 0/00", lu_ready_o, {hit_o, evict_o}); end
        lu_valid_i = 1'b0;
        bist_i = 1'b0;
        #1;
        checks++; if (lu_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bist_release: got %b want 1", lu_ready_o); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        int issueCycles = 0;
        applyStimulus(1'b0, 8'h00, 4'h7, 8'hFF, 8'h00, 8'h00);
        tick();
        lu_valid_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (err_timeout_o === 1'b1) break;
            if (evict_o === 1'b1) issueCycles++;
            tick();
        end
        checks++; if (err_timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %b want 1", err_timeout_o); end
        checks++; if (issueCycles != 16) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d want 16", issueCycles); end
        checks++; if (desc_valid_o !== 1'b0 || lu_ready_o !== 1'b1 || evict_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_after: got dv %b ready %b evict %b want 0 1 0", desc_valid_o, lu_ready_o, evict_o); end
        tick();
        checks++; if (err_timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b want 1", err_timeout_o); end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b0, 8'h00, 4'h6, 8'hFF, 8'hFF, 8'hFF);
        tick();
        applyStimulus(1'b0, 8'h00, 4'hC, 8'hF0, 8'h0F, 8'h00);
        tick();
        lu_valid_i = 1'b0;
        checks++; if (evict_o !== 1'b1 || desc_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre: got evict %b dv %b want 1 1", evict_o, desc_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({hit_o, evict_o} !== 2'b00 || ram_index_o !== 4'h0 || tag_dirty_o !== 8'h00) begin errors++; $display("[TB] FAIL arst_outputs: got %b/%h/%h want 00/0/00", {hit_o, evict_o}, ram_index_o, tag_dirty_o); end
        checks++; if (desc_valid_o !== 1'b0 || err_timeout_o !== 1'b0 || lu_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_flags: got dv %b err %b ready %b want 0 0 0", desc_valid_o, err_timeout_o, lu_ready_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (desc_valid_o !== 1'b0 || lu_ready_o !== 1'b1 || evict_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_release: got dv %b ready %b evict %b want 0 1 0", desc_valid_o, lu_ready_o, evict_o); end
    endtask

    initial begin
        rst_ni = 1'b0; bist_i = 1'b0; lu_valid_i = 1'b0; lu_hit_i = 1'b0;
        lu_hit_way_i = '0; lu_index_i = '0; lu_tag_valid_i = '0; lu_tag_dirty_i = '0;
        lu_spm_lock_i = '0; eb_way_ind_i = '0; eb_evict_i = 1'b0; eb_valid_i = 1'b0;
        eb_valid_plru_i = 1'b0; desc_ready_i = 1'b0;
        test_reset();
        test_miss();
        test_hit();
        test_no_way();
        test_back_to_back();
        test_fifo_full();
        test_bist();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
